mips_multicycle_sequencer: RTL

Clocked control FSM that sequences the MIPS fetch/decode/execute/memory/writeback datapath one instruction at a time.
- Owns the program counter, PC register and retired-instruction counter.
- Gates register-file and data-memory strobes per phase.
- Waits on a data-memory ready handshake with a timeout.
- Sits between the instruction memory / datapath top level and the register file, ALU and main memory.

---
 rtl/mips_multicycle_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_sequencer.sv
// Multicycle MIPS control sequencer: fetch/decode/exec/mem/wb/retire FSM that
// owns the PC and retired-instruction counter and gates datapath strobes per phase.
module mips_multicycle_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        ir_load,
  output logic        alu_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        reg_dest,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic [15:0] instr_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_RETIRE = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    K_RTYPE = 2'd0,
    K_LW    = 2'd1,
    K_SW    = 2'd2
  } kind_t;

  localparam logic [5:0]  OP_RTYPE = 6'b000000;
  localparam logic [5:0]  OP_LW    = 6'b100011;
  localparam logic [5:0]  OP_SW    = 6'b101011;
  localparam logic [5:0]  OP_HALT  = 6'b111111;
  localparam logic [31:0] PC_INC   = 32'(PC_STEP);
  localparam logic [7:0]  TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  tmo_q, tmo_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_RTYPE;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_dest   = 1'b0;
    alu_op     = 2'b00;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      // opcode is only looked at here; later phases use the latched kind_q
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin kind_d = K_RTYPE; state_d = S_EXEC; end
          OP_LW:    begin kind_d = K_LW;    state_d = S_EXEC; end
          OP_SW:    begin kind_d = K_SW;    state_d = S_EXEC; end
          OP_HALT:  state_d = S_HALT;
          default: begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        alu_en = 1'b1;
        tmo_d  = 8'd0;
        if (kind_q == K_RTYPE) begin
          alu_op   = 2'b10;
          reg_dest = 1'b1;
          state_d  = S_WB;
        end else begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end
      end
      // a ready arriving on the last allowed cycle still completes the access
      S_MEM: begin
        mem_read  = (kind_q == K_LW);
        mem_write = (kind_q == K_SW);
        if (mem_ready) begin
          state_d = (kind_q == K_LW) ? S_WB : S_RETIRE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (kind_q == K_LW);
        reg_dest   = (kind_q == K_RTYPE);
        state_d    = S_RETIRE;
      end
      S_RETIRE: begin
        pc_d    = pc_q + PC_INC;
        cnt_d   = cnt_q + 16'd1;
        state_d = start ? S_FETCH : S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign error       = err_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted      = (state_q == S_HALT);
  assign state_dbg   = state_q;

endmodule
